// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// fetch_entry_t is the default-width queue entry; the top rebuilds it at its own XLEN/ILEN.
package fetch_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam int          DEFAULT_ILEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  localparam int          PC_STEP          = 4;

  typedef struct packed {
    logic [DEFAULT_ILEN-1:0] instr;
    logic [DEFAULT_XLEN-1:0] pc;
    logic                    tlb_miss;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. The head entry is presented directly from storage,
// and the output reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; validity comes from count_q, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: default assigned first so this block never infers a latch.
  always_comb begin
    pop_data = '0;
    if (!empty) pop_data = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Decoupled fetch front end: issues sequential fetches under a credit limit, queues
// in-order responses for decode, and kills queued/in-flight work on redirect.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN            = DEFAULT_XLEN,
  parameter int              ILEN            = DEFAULT_ILEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  output logic [XLEN-1:0] req_pc,
  input  logic            req_ready,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_instr,
  input  logic            rsp_tlb_miss,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_tlb_miss,
  input  logic            out_ready
);

  localparam int              CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int              QCNT_W = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] STEP   = XLEN'(PC_STEP);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            tlb_miss;
  } entry_t;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   tail_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic              halted;
  logic              started;
  logic [XLEN-1:0]   redirect_aligned;
  logic              fire;
  logic              push;
  logic              drop;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [QCNT_W-1:0] q_count;
  entry_t            push_entry;
  entry_t            head_entry;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // started keeps req_valid low while reset is held and for the release cycle.
  assign req_valid = started & ~halted & ~redirect_valid
                   & (32'(outstanding) < MAX_OUTSTANDING)
                   & (32'(q_count) + 32'(outstanding) < DEPTH);
  assign req_pc    = fetch_pc;
  assign fire      = req_valid & req_ready;

  assign push = rsp_valid & ~redirect_valid & (drop_cnt == '0);
  assign drop = rsp_valid & ~redirect_valid & (drop_cnt != '0);
  assign pop  = out_valid & out_ready & ~redirect_valid;

  assign push_entry = '{instr: rsp_instr, pc: tail_pc, tlb_miss: rsp_tlb_miss};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      case ({fire, rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        tail_pc  <= redirect_aligned;
        halted   <= 1'b0;
        // Everything still unanswered after this cycle belongs to the killed stream.
        drop_cnt <= outstanding - CNT_W'(rsp_valid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + STEP;
        if (drop) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          tail_pc <= tail_pc + STEP;
          if (rsp_tlb_miss) halted <= 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign out_valid    = ~q_empty;
  assign out_instr    = head_entry.instr;
  assign out_pc       = head_entry.pc;
  assign out_tlb_miss = head_entry.tlb_miss;

  a_rsp_without_req : assert property (@(posedge clk) disable iff (!reset)
    !(rsp_valid && outstanding == '0));

  a_push_while_full : assert property (@(posedge clk) disable iff (!reset)
    !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: an in-order responder with programmable
// latency/hold feeds the DUT, and popped entries are compared to hand-derived values.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_tlb_miss;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_tlb_miss;
  logic        out_ready;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_instr      (rsp_instr),
    .rsp_tlb_miss   (rsp_tlb_miss),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_tlb_miss   (out_tlb_miss),
    .out_ready      (out_ready)
  );

  typedef struct {
    logic [31:0] pc;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        miss;
    int          cyc;
  } pop_t;

  pend_t       pend[$];
  pop_t        popped[$];
  int          cyc;
  int          lat;
  bit          hold;
  logic [31:0] miss_pc;
  int          fires;
  int          first_fire;
  int          first_out;
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_pc(int k);
    return (popped.size() > k) ? popped[k].pc : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] pop_instr(int k);
    return (popped.size() > k) ? popped[k].instr : 32'hxxxx_xxxx;
  endfunction

  function automatic logic pop_miss(int k);
    return (popped.size() > k) ? popped[k].miss : 1'bx;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    rsp_valid    = 1'b0;
    rsp_instr    = '0;
    rsp_tlb_miss = 1'b0;
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_valid    = 1'b1;
      rsp_instr    = instr_of(pend[0].pc);
      rsp_tlb_miss = (pend[0].pc == miss_pc);
      pend.delete(0);
    end
    #1;
    if (req_valid && req_ready) begin
      pend.push_back('{pc: req_pc, due: cyc + lat});
      fires++;
      if (first_fire < 0) first_fire = cyc;
    end
    if (out_valid && first_out < 0) first_out = cyc;
    if (out_valid && out_ready && !redirect_valid)
      popped.push_back('{pc: out_pc, instr: out_instr, miss: out_tlb_miss, cyc: cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic redirect_to(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
    popped.delete();
    fires = 0;
  endtask

  task automatic run_pops(int n, int budget);
    for (int i = 0; i < budget && popped.size() < n; i++) cycle();
    check("pop_budget", popped.size() >= n, 1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; hold = 0; fires = 0;
    miss_pc = 32'hFFFF_FFFF; first_fire = -1; first_out = -1;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_instr = '0; rsp_tlb_miss = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_valid", req_valid, 0);
    check("rst_req_pc", req_pc, 32'h0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_miss", out_tlb_miss, 0);

    // Streaming: one entry per cycle after a two-cycle fill.
    reset = 1'b1; req_ready = 1'b1; out_ready = 1'b1;
    run_pops(5, 20);
    for (int k = 0; k < 5; k++) check($sformatf("t1_pc%0d", k), pop_pc(k), 32'(4 * k));
    check("t1_instr0", pop_instr(0), instr_of(32'h0));
    check("t1_instr4", pop_instr(4), instr_of(32'h10));
    check("t1_fill", first_out - first_fire, 2);
    check("t1_rate", (popped.size() > 4) ? popped[4].cyc - popped[0].cyc : -1, 4);

    // Back-pressure: exactly DEPTH requests, head held stable.
    out_ready = 1'b0;
    redirect_to(32'h0);
    repeat (12) cycle();
    check("t2_fires", fires, 4);
    check("t2_req_valid", req_valid, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_pc", out_pc, 32'h0);
    check("t2_out_instr", out_instr, instr_of(32'h0));

    // Redirect with two requests in flight: both late responses dropped.
    hold = 1; out_ready = 1'b1;
    redirect_to(32'h80);
    repeat (4) cycle();
    check("t3_fires", fires, 2);
    check("t3_req_valid", req_valid, 0);
    redirect_to(32'h100);
    hold = 0;
    run_pops(2, 20);
    check("t3_pc0", pop_pc(0), 32'h100);
    check("t3_instr0", pop_instr(0), instr_of(32'h100));
    check("t3_pc1", pop_pc(1), 32'h104);

    // TLB miss on 0x8 halts fetch; 0xC was already in flight.
    miss_pc = 32'h8;
    redirect_to(32'h0);
    repeat (10) cycle();
    check("t4_pops", popped.size(), 4);
    check("t4_pc2", pop_pc(2), 32'h8);
    check("t4_miss2", pop_miss(2), 1);
    check("t4_pc3", pop_pc(3), 32'hC);
    check("t4_miss3", pop_miss(3), 0);
    check("t4_fires", fires, 4);
    check("t4_req_valid", req_valid, 0);
    redirect_to(32'h2000);
    miss_pc = 32'hFFFF_FFFF;
    run_pops(1, 20);
    check("t4_resume_pc", pop_pc(0), 32'h2000);
    check("t4_resume_miss", pop_miss(0), 0);

    // Unaligned redirect near the top of the address space wraps to 0.
    redirect_to(32'hFFFF_FFFA);
    run_pops(3, 20);
    check("t5_pc0", pop_pc(0), 32'hFFFF_FFF8);
    check("t5_pc1", pop_pc(1), 32'hFFFF_FFFC);
    check("t5_pc2", pop_pc(2), 32'h0);
    check("t5_instr2", pop_instr(2), instr_of(32'h0));

    // Credit-saturated queue: redirect together with a response and a pop.
    lat = 3; out_ready = 1'b0;
    redirect_to(32'h300);
    repeat (7) cycle();
    check("t6_inflight", pend.size(), 2);
    check("t6_fires", fires, 4);
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_pc", out_pc, 32'h300);
    out_ready = 1'b1;
    redirect_to(32'h400);
    check("t6_flushed", out_valid, 0);
    run_pops(1, 30);
    check("t6_pc0", pop_pc(0), 32'h400);
    check("t6_instr0", pop_instr(0), instr_of(32'h400));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
